// File: rtl/fp_result_accumulator_pkg.sv
// fp_result_accumulator_pkg: shared constants and FSM state encoding for the float result accumulator.
package fp_result_accumulator_pkg;
   localparam logic [31:0] FP_ZERO     = 32'h00000000;
   localparam logic [7:0]  FP_EXP_ONES = 8'hFF;
   typedef enum logic [1:0] {IDLE, WAIT_IN, ADD, FIN} state_t;
endpackage

// File: rtl/Task6_Addr_top.sv
// Task6_Addr_top: multi-cycle IEEE-754 single adder (round-to-nearest-even), started on a rising enable edge.
module Task6_Addr_top (
   input  logic        clk,
   input  logic        enable,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic [31:0] result,
   output logic        done
);
   logic        en_q, pend;
   logic [31:0] a_q, b_q, x, y, sum_c;
   logic [7:0]  exa, exb, d;
   logic [23:0] ma, mb;
   logic [49:0] w;
   logic [27:0] r;
   logic [26:0] n;
   logic [9:0]  e, sh;
   logic [4:0]  lz;
   logic [24:0] m;
   logic        inc;
   always_ff @(posedge clk) begin
      en_q <= enable;
      done <= 1'b0;
      if (enable && !en_q) begin
         a_q  <= dataa;
         b_q  <= datab;
         pend <= 1'b1;
      end else if (pend) begin
         result <= sum_c;
         done   <= 1'b1;
         pend   <= 1'b0;
      end
   end
   // x is the larger magnitude; it fixes the result sign and exponent
   always_comb begin
      x   = (a_q[30:0] < b_q[30:0]) ? b_q : a_q;
      y   = (a_q[30:0] < b_q[30:0]) ? a_q : b_q;
      exa = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
      exb = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
      ma  = {|x[30:23], x[22:0]};
      mb  = {|y[30:23], y[22:0]};
      d   = exa - exb;
      w   = {mb, 26'b0} >> ((d > 8'd26) ? 8'd26 : d);
      r   = (x[31] == y[31]) ? {1'b0, ma, 3'b0} + {1'b0, w[49:24], |w[23:0]}
                             : {1'b0, ma, 3'b0} - {1'b0, w[49:24], |w[23:0]};
      lz  = 5'd27;
      for (int i = 0; i < 27; i++) if (r[i]) lz = 5'(26 - i);
      sh  = ({5'b0, lz} < {2'b0, exa} - 10'd1) ? {5'b0, lz} : {2'b0, exa} - 10'd1;
      n   = r[27] ? {r[27:2], r[1] | r[0]} : r[26:0] << sh;
      e   = r[27] ? {2'b0, exa} + 10'd1 : {2'b0, exa} - sh;
      inc = n[2] & (n[1] | n[0] | n[3]);
      m   = {1'b0, n[26:3]} + {24'b0, inc};
      e   = m[24] ? e + 10'd1 : e;
      m   = m[24] ? m >> 1 : m;
      sum_c = (x[30:23] == 8'hFF) ? (((x[22:0] != 23'd0) || (y[30:23] == 8'hFF && x[31] != y[31])) ? 32'h7FC00000 : x)
            : (r == 28'd0)       ? {x[31] & y[31], 31'b0}
            : (e >= 10'd255)     ? {x[31], 8'hFF, 23'b0}
            :                      {x[31], m[23] ? e[7:0] : 8'd0, m[22:0]};
   end
endmodule

// File: rtl/fp_result_accumulator.sv
// fp_result_accumulator: sums N float results through the shared multi-cycle adder, pulsing done with the total.
// Define ACC_OVF_DETECT_EN to build the sticky non-finite (ovf) detector; otherwise ovf is tied low.
module fp_result_accumulator
   import fp_result_accumulator_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic             busy,
   output logic [31:0]      sum,
   output logic             done,
   output logic             ovf
);
   state_t           state, state_nx;
   logic [CNT_W-1:0] remaining;
   logic [31:0]      opb, add_res;
   logic             add_en, add_done;
   Task6_Addr_top u_add (
      .clk    (clk),
      .enable (add_en),
      .dataa  (sum),
      .datab  (opb),
      .result (add_res),
      .done   (add_done)
   );
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (count == '0) ? FIN : WAIT_IN;
         WAIT_IN: if (in_valid) state_nx = ADD;
         ADD:     if (add_done) state_nx = (remaining == CNT_W'(1)) ? FIN : WAIT_IN;
         default: state_nx = IDLE;
      endcase
      in_ready = state == WAIT_IN;
      busy     = state == WAIT_IN || state == ADD;
      add_en   = state == ADD;
      done     = state == FIN;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         sum       <= FP_ZERO;
         opb       <= FP_ZERO;
         remaining <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            sum       <= FP_ZERO;
            remaining <= count;
         end
         if (state == WAIT_IN && in_valid) opb <= in_data;
         if (state == ADD && add_done) begin
            sum       <= add_res;
            remaining <= remaining - CNT_W'(1);
         end
      end
   end
`ifdef ACC_OVF_DETECT_EN
   // exponent all ones after any addition means the total became inf or NaN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ovf <= 1'b0;
      else if (state == IDLE && start) ovf <= 1'b0;
      else if (state == ADD && add_done) ovf <= ovf | (add_res[30:23] == FP_EXP_ONES);
   end
`else
   assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_fp_result_accumulator.sv
// tb_fp_result_accumulator: directed and randomized checks of the accumulator against a real-arithmetic reference.
module tb_fp_result_accumulator;
   logic        clk = 0, reset_n = 0, start = 0, in_valid = 0;
   logic [15:0] count = 0;
   logic [31:0] in_data = 0;
   logic        in_ready, busy, done, ovf;
   logic [31:0] sum;
   int          passed = 0, total = 0;
   logic [31:0] r_sum;
   logic        r_ovf, r_rdy, r_fin;
   int          r_dones, r_used, r_lat, r_add;
   fp_result_accumulator #(.CNT_W(16)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .count    (count),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .busy     (busy),
      .sum      (sum),
      .done     (done),
      .ovf      (ovf)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask
   // exact conversion of a small dyadic real to single-precision bits
   function automatic logic [31:0] r2f(input real v);
      logic [63:0] b;
      if (v == 0.0) return 32'h0;
      b = $realtobits(v);
      return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
   endfunction
   function automatic real rv();
      real v;
      v = $urandom_range(1, 4000) / 4.0;
      return ($urandom_range(0, 1) == 1) ? -v : v;
   endfunction
   task automatic run(input int n, input logic [31:0] d[$], input bit hold, input int mid_at);
      int idx = 0;
      r_dones = 0; r_rdy = 0; r_add = 0; r_lat = -1; r_fin = 0;
      @(negedge clk); start = 1; count = 16'(n);
      @(negedge clk); start = 0;
      chk("ovf_clr", {31'b0, ovf}, 32'd0);
      for (int c = 0; c < 2000 && !r_fin; c++) begin
         in_valid = hold || (idx < d.size() && $urandom_range(0, 1) == 1);
         in_data  = (idx < d.size()) ? d[idx] : $urandom;
         start    = (c == mid_at);
         if (start) count = 16'd7;
         #1;
         if (in_ready) r_rdy = 1;
         if (busy && !in_ready) r_add++;
         if (done) begin r_dones++; r_sum = sum; r_ovf = ovf; r_lat = c; r_fin = 1; end
         if (in_valid && in_ready) idx++;
         @(negedge clk);
      end
      start = 0; in_valid = 0; r_used = idx;
      chk("done_seen", {31'b0, r_fin}, 32'd1);
      chk("done_pulse", {31'b0, done}, 32'd0);
      chk("sum_held", sum, r_sum);
   endtask
   initial begin
      logic [31:0] q[$];
      real         acc;
      int          n;
      logic        exp_ovf;
      #1;
      chk("rst_sum", sum, 32'h0);
      chk("rst_flags", {27'b0, in_ready, busy, done, ovf}, 32'd0);
      @(negedge clk); reset_n = 1;
      run(3, '{32'h3F800000, 32'h40000000, 32'h40400000}, 0, -1);
      chk("basic_sum", r_sum, 32'h40C00000);
      chk("basic_ovf", {31'b0, r_ovf}, 32'd0);
      chk("basic_used", 32'(r_used), 32'd3);
      run(0, '{}, 0, -1);
      chk("zero_sum", r_sum, 32'h0);
      chk("zero_lat", 32'(r_lat), 32'd0);
      chk("zero_rdy", {31'b0, r_rdy}, 32'd0);
      q = '{}; acc = 0.0;
      for (int i = 0; i < 2; i++) begin real v = rv(); acc += v; q.push_back(r2f(v)); end
      run(2, q, 1, 3);
      chk("bp_sum", r_sum, r2f(acc));
      chk("bp_used", 32'(r_used), 32'd2);
      chk("bp_dones", 32'(r_dones), 32'd1);
      chk("bp_add_seen", {31'b0, r_add > 0}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         n = $urandom_range(1, 8); q = '{}; acc = 0.0;
         for (int i = 0; i < n; i++) begin real v = rv(); acc += v; q.push_back(r2f(v)); end
         run(n, q, 0, -1);
         chk("rand_sum", r_sum, r2f(acc));
         chk("rand_used", 32'(r_used), 32'(n));
      end
`ifdef ACC_OVF_DETECT_EN
      exp_ovf = 1;
`else
      exp_ovf = 0;
`endif
      run(2, '{32'h7F7FFFFF, 32'h7F7FFFFF}, 0, -1);
      chk("ovf_sum", r_sum, 32'h7F800000);
      chk("ovf_flag", {31'b0, r_ovf}, {31'b0, exp_ovf});
      run(1, '{32'h3F800000}, 0, -1);
      chk("ovf_after_sum", r_sum, 32'h3F800000);
      chk("ovf_after_flag", {31'b0, r_ovf}, 32'd0);
      @(negedge clk); start = 1; count = 16'd1;
      @(negedge clk); start = 0; in_valid = 1; in_data = 32'h40000000;
      r_fin = 0;
      for (int c = 0; c < 50 && !r_fin; c++) begin
         #1;
         if (busy && !in_ready) r_fin = 1;
         else @(negedge clk);
      end
      chk("add_reached", {31'b0, r_fin}, 32'd1);
      in_valid = 0; reset_n = 0;
      #1;
      chk("mid_rst_sum", sum, 32'h0);
      chk("mid_rst_flags", {27'b0, in_ready, busy, done, ovf}, 32'd0);
      repeat (6) @(negedge clk);
      chk("mid_rst_discard", sum, 32'h0);
      reset_n = 1;
      run(1, '{32'h3F000000}, 0, -1);
      chk("post_rst_sum", r_sum, 32'h3F000000);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
